somador_serial_param: RTL and testbench
=======================================

Name: somador_serial_param

Overview:
- Multi-cycle, chunk-serial N-bit adder/subtractor. It is the parametrised successor to the single-bit full adder cell.
- Processes CHUNK bits per clock, LSB first, through a registered carry. This trades latency for area in the ULA datapath.
- Handshake: start / busy / done.
- Adds subtract mode and signed-overflow detection.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be at least 2.
- CHUNK, 2: bits processed per cycle. Must satisfy 1 ≤ CHUNK ≤ WIDTH, and WIDTH mod CHUNK = 0.
- Derived constant NSTEP = WIDTH/CHUNK; counter width = clog2(NSTEP)+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request an operation; sampled only when busy=0
- sub  in  1  0 = A+B+Cin, 1 = A−B (computed as A + ~B + 1; Cin ignored)
- A  in  WIDTH  operand A, captured on accepted start
- B  in  WIDTH  operand B, captured on accepted start
- Cin  in  1  carry-in for add mode, captured on accepted start
- R  out  WIDTH  result, held until next completion
- Cout  out  1  carry out of MSB; in sub mode 1 = no borrow
- Ovf  out  1  signed two's-complement overflow
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when R/Cout/Ovf update

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values while rst_n=0: R=0, Cout=0, Ovf=0, busy=0, done=0, state=IDLE. Internal operand shift registers, carry register and counter are all 0.
- States: IDLE, CALC.
- IDLE behaviour:
  - On a rising edge with start=1, capture A into the A shift register.
  - Capture B, or ~B when sub=1, into the B shift register.
  - Set the carry register to sub ? 1 : Cin, clear the step counter, set busy=1, go to CALC.
  - start=0 → stay in IDLE; outputs hold.
- CALC behaviour, each cycle:
  - Add the low CHUNK bits of both shift registers plus the carry register.
  - Shift the CHUNK sum bits into the result register from the MSB side.
  - Shift both operand registers right by CHUNK.
  - Update the carry register with the chunk carry-out.
  - Increment the counter.
- Last step (counter = NSTEP−1):
  - R ← full assembled result.
  - Cout ← carry out of bit WIDTH−1.
  - Ovf ← (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1).
  - done=1 for exactly the next cycle; busy=0 on the same edge; return to IDLE.
- Latency: start accepted at edge k → busy high during cycles k+1 … k+NSTEP → done high in cycle k+NSTEP+1 with R valid.
- Throughput: one operation per NSTEP+1 cycles. Back-to-back start is allowed in the done cycle, since busy=0 there.
- start while busy=1: ignored. No queuing; operands and sub are not re-sampled.
- Input changes on A/B/Cin/sub during CALC: no effect.
- R/Cout/Ovf change only on the completion edge. Between completions they hold the previous result, including while busy=1 for the next operation.
- Reset asserted mid-operation: immediate abort, all outputs to reset values, no done pulse. After deassertion the block idles until a new start.
- CHUNK = WIDTH: NSTEP = 1. busy is high for one cycle, done follows in the next cycle.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

Test Plan:
1. WIDTH=8, CHUNK=2, sub=0, A=0x5A, B=0x3C, Cin=0 → busy high 4 cycles, then done pulse with R=0x96, Cout=0, Ovf=1.
2. A=0xFF, B=0x01, Cin=0, sub=0 → R=0x00, Cout=1, Ovf=0. Repeat with Cin=1 → R=0x01, Cout=1, Ovf=0.
3. Subtraction: sub=1, A=0x10, B=0x20, Cin=1 → R=0xF0, Cout=0, Ovf=0 (Cin ignored). Then A=0x80, B=0x01 → R=0x7F, Cout=1, Ovf=1.
4. Pulse start with A=0x01, B=0x01. Two cycles later, assert start with A=0xAA, B=0x55 → first result R=0x02, single done pulse, second request ignored. A start held high in the done cycle begins a new operation.
5. Start A=0x5A, B=0x3C; drop rst_n in the 2nd CALC cycle → all outputs 0 asynchronously, no done. After release, A=0x03, B=0x04 → R=0x07.
6. Parameter sweep (WIDTH,CHUNK) ∈ {(8,1),(8,8),(16,4),(32,8)} with 1000 random add/sub ops per configuration → R/Cout/Ovf match a reference model. Latency = NSTEP+1 cycles from the accepted start to done.

Source files
------------

// File: rtl/somador_serial_param.sv
// somador_serial_param: chunk-serial WIDTH-bit adder/subtractor.
// Each clock adds CHUNK bits, LSB first, through a registered carry.
// Handshake is start/busy/done. R, Cout and Ovf hold between completions.
// Subtraction is computed as A + ~B + 1. Cout=1 then means "no borrow".
module somador_serial_param #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] R,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy,
    output logic             done
);

    localparam int NSTEP = WIDTH / CHUNK;
    localparam int CNTW  = $clog2(NSTEP) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_finish;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [CNTW-1:0]   r_cnt;

    logic [WIDTH-1:0]  r_r;
    logic              r_cout;
    logic              r_ovf;
    logic              r_done;

    logic [CHUNK:0]    w_chunk_sum;
    logic              w_msb_cin;
    logic              w_last;
    logic [WIDTH-1:0]  w_result;

    // The chunk adder works on the low CHUNK bits of both operand registers.
    assign w_chunk_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, r_carry};

    // The carry into the top bit of the chunk is recovered from its sum bit.
    // On the last step that top bit is bit WIDTH-1 of the whole word.
    assign w_msb_cin = w_chunk_sum[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];

    assign w_last = (r_cnt == CNTW'(NSTEP - 1));

    // Partial result assembly. Chunks enter from the MSB side. After NSTEP-1
    // steps the register holds every chunk except the one now being added.
    if (CHUNK == WIDTH) begin : g_single
        assign w_result = w_chunk_sum[CHUNK-1:0];
    end else begin : g_multi
        logic [WIDTH-CHUNK-1:0] r_acc;

        assign w_result = {w_chunk_sum[CHUNK-1:0], r_acc};

        // Shift the newly computed chunk into the partial result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (r_state == S_CALC) begin
                r_acc <= w_result[WIDTH-1:CHUNK];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops take non-blocking assignments. Then every flop samples
        // pre-edge values, whatever order the blocks are evaluated in.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. It accepts start only in IDLE and finishes on the last step.
    always_comb begin
        // NOTE: every signal gets a default before the case statement.
        // Otherwise an unassigned path infers a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    // Operand capture, per-chunk datapath stepping and result commit.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all datapath registers are reset, not only the control
        // state. That way an aborted operation leaves nothing stale behind.
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_r     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_a     <= A;
                r_b     <= sub ? ~B : B;
                r_carry <= sub ? 1'b1 : Cin;
                r_cnt   <= '0;
            end else if (r_state == S_CALC) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_carry <= w_chunk_sum[CHUNK];
                r_cnt   <= r_cnt + CNTW'(1);
            end
            if (w_finish) begin
                r_r    <= w_result;
                r_cout <= w_chunk_sum[CHUNK];
                r_ovf  <= w_msb_cin ^ w_chunk_sum[CHUNK];
            end
        end
    end

    assign R    = r_r;
    assign Cout = r_cout;
    assign Ovf  = r_ovf;
    assign busy = (r_state == S_CALC);
    assign done = r_done;

endmodule

// File: tb/tb_somador_serial_param.sv
// Testbench for somador_serial_param.
// Directed cases run on an 8-bit, 2-bit-chunk instance. A randomized sweep
// covers four other width/chunk configurations. Each result is compared
// with an arithmetic reference model.
module tb_somador_serial_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Directed-test instance: WIDTH=8, CHUNK=2
    logic       start, sub, cin;
    logic [7:0] a, b, r;
    logic       cout, ovf, busy, done;

    somador_serial_param #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .A(a), .B(b), .Cin(cin),
        .R(r), .Cout(cout), .Ovf(ovf), .busy(busy), .done(done)
    );

    // Sweep instances share inputs; A/B are truncated per width
    localparam int WS [4] = '{8, 8, 16, 32};
    localparam int CS [4] = '{1, 8, 4, 8};

    logic             sw_start, sw_sub, sw_cin;
    logic [31:0]      sw_a, sw_b;
    logic [3:0][31:0] sw_r;
    logic [3:0]       sw_cout, sw_ovf, sw_busy, sw_done;

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        logic [WS[g]-1:0] w_r;
        somador_serial_param #(.WIDTH(WS[g]), .CHUNK(CS[g])) u_sw (
            .clk(clk), .rst_n(rst_n), .start(sw_start), .sub(sw_sub),
            .A(sw_a[WS[g]-1:0]), .B(sw_b[WS[g]-1:0]), .Cin(sw_cin),
            .R(w_r), .Cout(sw_cout[g]), .Ovf(sw_ovf[g]),
            .busy(sw_busy[g]), .done(sw_done[g])
        );
        assign sw_r[g] = 32'(w_r);
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic void ref_model(input int w, input longint va, input longint vb,
                                      input bit s, input bit c,
                                      output longint vr, output bit co, output bit ov);
        longint m, sa, sb, t;
        m  = 64'sd1 <<< w;
        sa = (va >= m / 2) ? va - m : va;
        sb = (vb >= m / 2) ? vb - m : vb;
        if (s) begin
            vr = (va - vb + m) % m;
            co = (va >= vb);
            t  = sa - sb;
        end else begin
            vr = (va + vb + longint'(c)) % m;
            co = (va + vb + longint'(c)) >= m;
            t  = sa + sb + longint'(c);
        end
        ov = (t < -(m / 2)) || (t > m / 2 - 1);
    endfunction

    // One directed operation: latency, busy length, hold, result, single pulse
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic icin, input logic isub, input logic [7:0] prev_r,
                          input logic [7:0] er, input logic ecout, input logic eovf);
        int lat, bcnt;
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'hEE; b = 8'hEE; cin = 1'b1; sub = ~isub;   // must not matter
        lat = 1; bcnt = 0;
        check({tag, "_hold"}, r, prev_r);
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 5);
        check({tag, "_busycyc"}, bcnt, 4);
        check({tag, "_r"}, r, er);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_ovf"}, ovf, eovf);
        tick();
        check({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n, seen;
        int lat [4];
        int bcnt[4];
        logic [31:0] got_r[4];
        logic        got_c[4], got_o[4];
        longint vr, mask;
        bit     co, ov;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        sw_start = 1'b0; sw_sub = 1'b0; sw_cin = 1'b0; sw_a = '0; sw_b = '0;
        #12;
        check("rst_r", r, 8'h00);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic add, carries and signed overflow
        run_op("t1_add",   8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h96, 1'b0, 1'b1);
        run_op("t2_wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h96, 8'h00, 1'b1, 1'b0);
        run_op("t2_cin",   8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0);
        // Subtraction, Cin ignored
        run_op("t3_sub",   8'h10, 8'h20, 1'b1, 1'b1, 8'h01, 8'hF0, 1'b0, 1'b0);
        run_op("t3_subov", 8'h80, 8'h01, 1'b0, 1'b1, 8'hF0, 8'h7F, 1'b1, 1'b1);

        // Start while busy is ignored; start held into the done cycle is accepted
        a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 8'hAA; b = 8'h55; start = 1'b1;
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        check("t4_first_r", r, 8'h02);
        check("t4_first_done", done, 1'b1);
        tick();
        start = 1'b0;
        check("t4_single_pulse", done, 1'b0);
        check("t4_restart_busy", busy, 1'b1);
        check("t4_hold", r, 8'h02);
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        check("t4_second_r", r, 8'hFF);
        check("t4_second_cout", cout, 1'b0);
        tick();

        // Reset mid-operation aborts at once
        a = 8'h5A; b = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t5_abort_r", r, 8'h00);
        check("t5_abort_busy", busy, 1'b0);
        check("t5_abort_done", done, 1'b0);
        check("t5_abort_cout", cout, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) seen++;
            tick();
        end
        check("t5_idle_after_reset", seen, 0);
        run_op("t5_after", 8'h03, 8'h04, 1'b0, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0);

        // Randomized sweep across configurations, all started together
        for (int i = 0; i < 1000; i++) begin
            sw_a   = $urandom;
            sw_b   = $urandom;
            sw_sub = 1'($urandom_range(0, 1));
            sw_cin = 1'($urandom_range(0, 1));
            if (i % 97 == 0) begin sw_a = '1; sw_b = 32'h1; end
            if (i % 89 == 0) begin sw_a = 32'h8000_0080; sw_b = 32'h1; sw_sub = 1'b1; end
            sw_start = 1'b1;
            tick();
            sw_start = 1'b0;
            for (int g = 0; g < 4; g++) begin lat[g] = 0; bcnt[g] = 0; end
            for (int t = 1; t <= 20; t++) begin
                seen = 0;
                for (int g = 0; g < 4; g++) begin
                    if (sw_busy[g]) bcnt[g]++;
                    if (sw_done[g] && lat[g] == 0) begin
                        lat[g]   = t;
                        got_r[g] = sw_r[g];
                        got_c[g] = sw_cout[g];
                        got_o[g] = sw_ovf[g];
                    end
                    if (lat[g] != 0) seen++;
                end
                if (seen == 4) break;
                tick();
            end
            for (int g = 0; g < 4; g++) begin
                mask = (64'sd1 <<< WS[g]) - 1;
                ref_model(WS[g], longint'(sw_a) & mask, longint'(sw_b) & mask,
                          sw_sub, sw_cin, vr, co, ov);
                check($sformatf("sw%0d_r", g), got_r[g], vr);
                check($sformatf("sw%0d_cout", g), got_c[g], co);
                check($sformatf("sw%0d_ovf", g), got_o[g], ov);
                check($sformatf("sw%0d_lat", g), lat[g], WS[g] / CS[g] + 1);
                check($sformatf("sw%0d_busy", g), bcnt[g], WS[g] / CS[g]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
